varint_decode_fsm: RTL and testbench

Upstream feeder for the output-merge stage. It pops protobuf-encoded bytes, each tagged with a field index, from a show-ahead input byte FIFO. It reassembles each base-128 varint (little-endian 7-bit groups, MSB = continuation) into a 64-bit value. It pushes the value and its field index into the varint FIFO, whose head the merge stage reads as varint data and varint out-index.

---
 rtl/varint_decode_fsm_if.sv | 26 ++
 rtl/varint_decode_fsm.sv | 141 ++++++++++++++
 tb/tb_varint_decode_fsm.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/varint_decode_fsm_if.sv
// Handshake bundle between the show-ahead input byte FIFO, the varint decoder
// and the varint output FIFO read by the merge stage.
interface varint_decode_fsm_if #(
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 10
);
    logic               in_fifo_empty;
    logic [7:0]         in_fifo_data;
    logic [INDEX_W-1:0] in_fifo_index;
    logic               in_fifo_pop;
    logic               vout_fifo_full;
    logic               vout_fifo_clr;
    logic               vout_fifo_push;
    logic [DATA_W-1:0]  vout_fifo_data;
    logic [INDEX_W-1:0] vout_fifo_index;

    modport master (
        input  in_fifo_empty, in_fifo_data, in_fifo_index, vout_fifo_full,
        output in_fifo_pop, vout_fifo_clr, vout_fifo_push, vout_fifo_data, vout_fifo_index
    );

    modport slave (
        output in_fifo_empty, in_fifo_data, in_fifo_index, vout_fifo_full,
        input  in_fifo_pop, vout_fifo_clr, vout_fifo_push, vout_fifo_data, vout_fifo_index
    );
endinterface

// File: rtl/varint_decode_fsm.sv
// Base-128 varint decoder: pops tagged bytes from a show-ahead FIFO, rebuilds
// each little-endian 7-bit-group varint and pushes (value, field index) downstream.
module varint_decode_fsm #(
    parameter int DATA_W    = 64,
    parameter int INDEX_W   = 10,
    parameter int MAX_BYTES = 10,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    varint_decode_fsm_if.master bus,
    output logic                overflow_err,
    output logic [CNT_W-1:0]    varint_count
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);

    typedef enum logic [3:0] {
        ST_INIT    = 4'b0001,
        ST_WAIT    = 4'b0010,
        ST_PUSH    = 4'b0100,
        ST_DISCARD = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [NB_W-1:0]    nbytes_q, nbytes_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pop_s, push_s, clr_s;

    // Places a 7-bit group at its slot; bits landing above DATA_W-1 fall off.
    function automatic logic [DATA_W-1:0] place_group(input logic [6:0] payload,
                                                      input logic [NB_W-1:0] slot);
        logic [DATA_W-1:0] wide;
        int unsigned       sh;
        wide = {{(DATA_W-7){1'b0}}, payload};
        sh   = 32'(slot) * 32'd7;
        return wide << sh;
    endfunction

    // Next-state, datapath update and handshake strobes.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        nbytes_d = nbytes_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        clr_s    = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_s    = 1'b1;
                acc_d    = {DATA_W{1'b0}};
                nbytes_d = {NB_W{1'b0}};
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.in_fifo_empty) begin
                    pop_s    = 1'b1;
                    acc_d    = acc_q | place_group(bus.in_fifo_data[6:0], nbytes_q);
                    nbytes_d = nbytes_q + NB_W'(1);
                    if (nbytes_q == {NB_W{1'b0}}) begin
                        idx_d = bus.in_fifo_index;
                    end else begin
                        idx_d = idx_q;
                    end
                    if (!bus.in_fifo_data[7]) begin
                        state_d = ST_PUSH;
                    end else if (nbytes_q == NB_W'(MAX_BYTES - 1)) begin
                        // Too long to be a legal varint: flag it and skip to its end.
                        ovf_d    = 1'b1;
                        acc_d    = {DATA_W{1'b0}};
                        nbytes_d = {NB_W{1'b0}};
                        state_d  = ST_DISCARD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PUSH: begin
                if (!bus.vout_fifo_full) begin
                    push_s   = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    acc_d    = {DATA_W{1'b0}};
                    nbytes_d = {NB_W{1'b0}};
                    state_d  = ST_WAIT;
                end else begin
                    state_d = ST_PUSH;
                end
            end
            ST_DISCARD: begin
                if (!bus.in_fifo_empty) begin
                    pop_s = 1'b1;
                    if (!bus.in_fifo_data[7]) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            acc_q    <= {DATA_W{1'b0}};
            idx_q    <= {INDEX_W{1'b0}};
            nbytes_q <= {NB_W{1'b0}};
            ovf_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            nbytes_q <= nbytes_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobes must react to empty/full in the same cycle; reset masks them.
    assign bus.in_fifo_pop     = pop_s & ~reset;
    assign bus.vout_fifo_push  = push_s & ~reset;
    assign bus.vout_fifo_clr   = clr_s & ~reset;
    assign bus.vout_fifo_data  = acc_q;
    assign bus.vout_fifo_index = idx_q;
    assign overflow_err        = ovf_q;
    assign varint_count        = cnt_q;
endmodule

// File: tb/tb_varint_decode_fsm.sv
// Bench for varint_decode_fsm: directed scenarios plus random varints encoded
// from known values, with FIFO models on both sides and random stalls/gaps.
module tb_varint_decode_fsm;
    localparam int DATA_W  = 64;
    localparam int INDEX_W = 10;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               overflow_err;
    logic [CNT_W-1:0]   varint_count;

    varint_decode_fsm_if #(.DATA_W(DATA_W), .INDEX_W(INDEX_W)) vif ();

    varint_decode_fsm #(
        .DATA_W(DATA_W), .INDEX_W(INDEX_W), .MAX_BYTES(10), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (vif),
        .overflow_err(overflow_err),
        .varint_count(varint_count)
    );

    always #5 clk = ~clk;

    logic [17:0] byte_q[$];   // {index, byte}
    logic [73:0] exp_q[$];    // {index, value}
    int n_checks = 0, n_errors = 0, model_count = 0, clr_count = 0;
    bit hold_empty = 1'b0, rand_stall = 1'b0;
    logic s_pop, s_push, s_clr;
    logic [63:0] s_data;
    logic [9:0]  s_index;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        vif.in_fifo_empty = (byte_q.size() == 0) || hold_empty;
        if (byte_q.size() != 0) {vif.in_fifo_index, vif.in_fifo_data} = byte_q[0];
        else {vif.in_fifo_index, vif.in_fifo_data} = 18'd0;
    endtask

    task automatic step();
        logic [73:0] e;
        logic [17:0] dropped;
        @(negedge clk);
        s_pop   = vif.in_fifo_pop;
        s_push  = vif.vout_fifo_push;
        s_clr   = vif.vout_fifo_clr;
        s_data  = vif.vout_fifo_data;
        s_index = vif.vout_fifo_index;
        check_val("pop_while_empty", 64'(s_pop & vif.in_fifo_empty), 64'd0);
        check_val("push_while_full", 64'(s_push & vif.vout_fifo_full), 64'd0);
        if (s_clr) clr_count++;
        if (s_push) begin
            if (exp_q.size() == 0) check_val("unexpected_push", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check_val("push_data", s_data, e[63:0]);
                check_val("push_index", 64'(s_index), 64'(e[73:64]));
            end
        end
        @(posedge clk);
        #1;
        if (s_pop && byte_q.size() != 0) dropped = byte_q.pop_front();
        if (rand_stall) begin
            vif.vout_fifo_full = ($urandom_range(0, 3) == 0);
            hold_empty = ($urandom_range(0, 4) == 0);
        end
        refresh();
    endtask

    task automatic put_byte(input logic [7:0] b, input logic [9:0] tag);
        byte_q.push_back({tag, b});
        refresh();
    endtask

    task automatic expect_push(input logic [63:0] v, input logic [9:0] tag);
        exp_q.push_back({tag, v});
        model_count++;
    endtask

    // Minimal LEB128 encoding; continuation bytes carry random tags that must be ignored.
    task automatic enc(input logic [63:0] v, input logic [9:0] tag);
        logic [63:0] r;
        logic [7:0]  b;
        logic [9:0]  t;
        r = v;
        t = tag;
        do begin
            b = {1'b0, r[6:0]};
            r = r >> 7;
            if (r != 64'd0) b[7] = 1'b1;
            byte_q.push_back({t, b});
            t = 10'($urandom_range(0, 1023));
        end while (r != 64'd0);
        expect_push(v, tag);
        refresh();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((byte_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check_val("drain_timeout", 64'(byte_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        check_val("rst_pop", 64'(s_pop), 64'd0);
        check_val("rst_push", 64'(s_push), 64'd0);
        check_val("rst_clr", 64'(s_clr), 64'd0);
        check_val("rst_data", s_data, 64'd0);
        check_val("rst_index", 64'(s_index), 64'd0);
        check_val("rst_ovf", 64'(overflow_err), 64'd0);
        check_val("rst_count", 64'(varint_count), 64'd0);
        reset = 1'b0;
        model_count = 0;
        clr_count = 0;
        step();
        check_val("init_clr", 64'(s_clr), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] p3, q3;
        logic [4:0] p5, q5;
        logic [63:0] v;
        bit any_ovf;
        reset = 1'b1;
        vif.vout_fifo_full = 1'b0;
        refresh();
        do_reset();

        // 1: {0x96,0x01} tag 5 -> 150 one cycle after the second pop
        put_byte(8'h96, 10'd5);
        put_byte(8'h01, 10'd5);
        expect_push(64'd150, 10'd5);
        p3 = 3'b011; q3 = 3'b100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t1_pop", 64'(s_pop), 64'(p3[i]));
            check_val("t1_push", 64'(s_push), 64'(q3[i]));
        end
        check_val("t1_count", 64'(varint_count), 64'd1);
        check_val("t1_clr_once", 64'(clr_count), 64'd1);

        // 2: back-to-back; pops in cycles 0,2,3 and pushes in 1,4
        put_byte(8'h01, 10'd3);
        put_byte(8'hAC, 10'd4);
        put_byte(8'h02, 10'd9);
        expect_push(64'd1, 10'd3);
        expect_push(64'd300, 10'd4);
        p5 = 5'b01101; q5 = 5'b10010;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t2_pop", 64'(s_pop), 64'(p5[i]));
            check_val("t2_push", 64'(s_push), 64'(q5[i]));
        end
        check_val("t2_count", 64'(varint_count), 64'd3);

        // 3: ten-byte maximum varint
        for (int i = 0; i < 9; i++) put_byte(8'hFF, 10'd7);
        put_byte(8'h01, 10'd7);
        expect_push(64'hFFFF_FFFF_FFFF_FFFF, 10'd7);
        drain(50);
        check_val("t3_ovf", 64'(overflow_err), 64'd0);
        check_val("t3_count", 64'(varint_count), 64'd4);

        // 4: full stall for five cycles; no push, no pop, stable outputs
        vif.vout_fifo_full = 1'b1;
        put_byte(8'h2A, 10'd9);
        put_byte(8'h05, 10'd2);
        expect_push(64'd42, 10'd9);
        expect_push(64'd5, 10'd2);
        step();
        check_val("t4_first_pop", 64'(s_pop), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t4_stall_push", 64'(s_push), 64'd0);
            check_val("t4_stall_pop", 64'(s_pop), 64'd0);
            check_val("t4_stall_data", s_data, 64'd42);
            check_val("t4_stall_index", 64'(s_index), 64'd9);
        end
        vif.vout_fifo_full = 1'b0;
        step();
        check_val("t4_release_push", 64'(s_push), 64'd1);
        check_val("t4_release_pop", 64'(s_pop), 64'd0);
        drain(20);
        check_val("t4_count", 64'(varint_count), 64'd6);

        // 5: overlong varint is dropped and flagged; next varint still decodes
        do_reset();
        for (int i = 0; i < 11; i++) put_byte(8'h80, 10'd1);
        put_byte(8'h05, 10'd1);
        put_byte(8'h07, 10'd6);
        expect_push(64'd7, 10'd6);
        drain(50);
        check_val("t5_ovf", 64'(overflow_err), 64'd1);
        check_val("t5_count", 64'(varint_count), 64'd1);

        // 6: reset mid-varint discards the partial value
        put_byte(8'h96, 10'd5);
        step();
        check_val("t6_pop", 64'(s_pop), 64'd1);
        do_reset();
        put_byte(8'h01, 10'd8);
        expect_push(64'd1, 10'd8);
        drain(20);
        check_val("t6_count", 64'(varint_count), 64'd1);

        // Random varints, occasional overlong garbage, random stalls and gaps
        any_ovf = 1'b0;
        rand_stall = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                any_ovf = 1'b1;
                for (int k = 0; k < 10 + $urandom_range(0, 4); k++)
                    put_byte(8'h80 | 8'($urandom_range(0, 127)), 10'($urandom_range(0, 1023)));
                put_byte(8'($urandom_range(0, 127)), 10'd0);
            end
            v = {32'($urandom()), 32'($urandom())} >> $urandom_range(0, 63);
            enc(v, 10'($urandom_range(0, 1023)));
        end
        drain(20000);
        rand_stall = 1'b0;
        hold_empty = 1'b0;
        vif.vout_fifo_full = 1'b0;
        refresh();
        step();
        check_val("rand_count", 64'(varint_count), 64'(16'(model_count)));
        check_val("rand_ovf", 64'(overflow_err), 64'(any_ovf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
